// File: rtl/id_ex_stage.sv
// ID/EX pipeline register: captures decoded control, immediate and operands,
// detects load-use hazards against the load in EX and counts inserted bubbles.
module id_ex_stage #(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic              flush,
  input  logic              id_valid,
  input  logic [31:0]       id_inst,
  input  logic              id_we_st,
  input  logic              id_we_r,
  input  logic              id_ma,
  input  logic [4:0]        id_dest,
  input  logic [3:0]        id_alu,
  input  logic [15:0]       id_imm,
  input  logic              id_cin,
  input  logic [DATA_W-1:0] id_a,
  input  logic [DATA_W-1:0] id_b,
  output logic              ex_valid,
  output logic              ex_we_st,
  output logic              ex_we_r,
  output logic              ex_ma,
  output logic [4:0]        ex_dest,
  output logic [3:0]        ex_alu,
  output logic [15:0]       ex_imm,
  output logic              ex_cin,
  output logic [DATA_W-1:0] ex_a,
  output logic [DATA_W-1:0] ex_b,
  output logic [4:0]        ex_rs,
  output logic [4:0]        ex_rt,
  output logic              stall_id,
  output logic [CNT_W-1:0]  bubble_cnt
);

  localparam logic [5:0]       OP_RTYPE = 6'b000000;
  localparam logic [5:0]       OP_SW    = 6'b101011;
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [5:0]        opcode_s;
  logic [4:0]        rs_s;
  logic [4:0]        rt_s;
  logic              uses_rt_s;
  logic              hazard_s;
  logic              unused_inst_s;

  logic              ex_valid_r;
  logic              ex_we_st_r;
  logic              ex_we_r_r;
  logic              ex_ma_r;
  logic [4:0]        ex_dest_r;
  logic [3:0]        ex_alu_r;
  logic [15:0]       ex_imm_r;
  logic              ex_cin_r;
  logic [DATA_W-1:0] ex_a_r;
  logic [DATA_W-1:0] ex_b_r;
  logic [4:0]        ex_rs_r;
  logic [4:0]        ex_rt_r;
  logic [CNT_W-1:0]  bubble_cnt_r;

  assign unused_inst_s = ^id_inst[15:0];

  // Decode source-register usage and evaluate the load-use hazard
  always_comb begin
    opcode_s  = id_inst[31:26];
    rs_s      = id_inst[25:21];
    rt_s      = id_inst[20:16];
    uses_rt_s = 1'b0;
    case (opcode_s)
      OP_RTYPE: uses_rt_s = 1'b1;
      OP_SW:    uses_rt_s = 1'b1;
      default:  uses_rt_s = 1'b0;
    endcase
    // Register 0 is never a real destination, so it never stalls
    hazard_s = id_valid & ex_valid_r & ex_ma_r & (ex_dest_r != 5'd0) &
               ((ex_dest_r == rs_s) | (uses_rt_s & (ex_dest_r == rt_s)));
  end

  assign stall_id = hazard_s & ~flush;

  // EX registers: reset, then flush (ignores en), then hold, then bubble, then load
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ex_valid_r   <= 1'b0;
      ex_we_st_r   <= 1'b0;
      ex_we_r_r    <= 1'b0;
      ex_ma_r      <= 1'b0;
      ex_dest_r    <= 5'd0;
      ex_alu_r     <= 4'd0;
      ex_imm_r     <= 16'd0;
      ex_cin_r     <= 1'b0;
      ex_a_r       <= {DATA_W{1'b0}};
      ex_b_r       <= {DATA_W{1'b0}};
      ex_rs_r      <= 5'd0;
      ex_rt_r      <= 5'd0;
      bubble_cnt_r <= {CNT_W{1'b0}};
    end else if (flush) begin
      ex_valid_r   <= 1'b0;
      ex_we_st_r   <= 1'b0;
      ex_we_r_r    <= 1'b0;
      ex_ma_r      <= 1'b0;
      ex_dest_r    <= 5'd0;
      ex_alu_r     <= 4'd0;
      ex_imm_r     <= 16'd0;
      ex_cin_r     <= 1'b0;
      ex_a_r       <= {DATA_W{1'b0}};
      ex_b_r       <= {DATA_W{1'b0}};
      ex_rs_r      <= 5'd0;
      ex_rt_r      <= 5'd0;
    end else if (en) begin
      if (hazard_s) begin
        ex_valid_r <= 1'b0;
        ex_we_st_r <= 1'b0;
        ex_we_r_r  <= 1'b0;
        ex_ma_r    <= 1'b0;
        if (bubble_cnt_r != CNT_MAX) begin
          bubble_cnt_r <= bubble_cnt_r + CNT_ONE;
        end
      end else begin
        ex_valid_r <= id_valid;
        ex_we_st_r <= id_we_st & id_valid;
        ex_we_r_r  <= id_we_r & id_valid;
        ex_ma_r    <= id_ma & id_valid;
        ex_dest_r  <= id_dest;
        ex_alu_r   <= id_alu;
        ex_imm_r   <= id_imm;
        ex_cin_r   <= id_cin;
        ex_a_r     <= id_a;
        ex_b_r     <= id_b;
        ex_rs_r    <= rs_s;
        ex_rt_r    <= rt_s;
      end
    end
  end

  assign ex_valid   = ex_valid_r;
  assign ex_we_st   = ex_we_st_r;
  assign ex_we_r    = ex_we_r_r;
  assign ex_ma      = ex_ma_r;
  assign ex_dest    = ex_dest_r;
  assign ex_alu     = ex_alu_r;
  assign ex_imm     = ex_imm_r;
  assign ex_cin     = ex_cin_r;
  assign ex_a       = ex_a_r;
  assign ex_b       = ex_b_r;
  assign ex_rs      = ex_rs_r;
  assign ex_rt      = ex_rt_r;
  assign bubble_cnt = bubble_cnt_r;

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed bench for id_ex_stage with a 4-bit bubble counter so saturation is reachable.
module tb_id_ex_stage;

  localparam int DATA_W = 32;
  localparam int CNT_W  = 4;

  logic              clk = 1'b0;
  logic              rst_n, en, flush, id_valid;
  logic [31:0]       id_inst;
  logic              id_we_st, id_we_r, id_ma, id_cin;
  logic [4:0]        id_dest;
  logic [3:0]        id_alu;
  logic [15:0]       id_imm;
  logic [DATA_W-1:0] id_a, id_b;
  logic              ex_valid, ex_we_st, ex_we_r, ex_ma, ex_cin, stall_id;
  logic [4:0]        ex_dest, ex_rs, ex_rt;
  logic [3:0]        ex_alu;
  logic [15:0]       ex_imm;
  logic [DATA_W-1:0] ex_a, ex_b;
  logic [CNT_W-1:0]  bubble_cnt;

  int cmps = 0;
  int errs = 0;

  always #5 clk = ~clk;

  id_ex_stage #(.DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .flush(flush),
    .id_valid(id_valid), .id_inst(id_inst), .id_we_st(id_we_st), .id_we_r(id_we_r),
    .id_ma(id_ma), .id_dest(id_dest), .id_alu(id_alu), .id_imm(id_imm),
    .id_cin(id_cin), .id_a(id_a), .id_b(id_b),
    .ex_valid(ex_valid), .ex_we_st(ex_we_st), .ex_we_r(ex_we_r), .ex_ma(ex_ma),
    .ex_dest(ex_dest), .ex_alu(ex_alu), .ex_imm(ex_imm), .ex_cin(ex_cin),
    .ex_a(ex_a), .ex_b(ex_b), .ex_rs(ex_rs), .ex_rt(ex_rt),
    .stall_id(stall_id), .bubble_cnt(bubble_cnt)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    cmps++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_add(input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd,
                           input logic [31:0] a, input logic [31:0] b);
    id_valid = 1'b1; id_inst = {6'b000000, rs, rt, rd, 11'd32};
    id_we_st = 1'b0; id_we_r = 1'b1; id_ma = 1'b0; id_dest = rd;
    id_alu = 4'd2; id_imm = 16'd0; id_cin = 1'b0; id_a = a; id_b = b;
  endtask

  task automatic drive_lw(input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] dest,
                          input logic [15:0] imm);
    id_valid = 1'b1; id_inst = {6'b100011, rs, rt, imm};
    id_we_st = 1'b0; id_we_r = 1'b1; id_ma = 1'b1; id_dest = dest;
    id_alu = 4'd2; id_imm = imm; id_cin = 1'b0; id_a = 32'h0000_1000; id_b = 32'h0;
  endtask

  task automatic drive_sw(input logic [4:0] rs, input logic [4:0] rt, input logic [15:0] imm);
    id_valid = 1'b1; id_inst = {6'b101011, rs, rt, imm};
    id_we_st = 1'b1; id_we_r = 1'b0; id_ma = 1'b1; id_dest = 5'd0;
    id_alu = 4'd2; id_imm = imm; id_cin = 1'b0; id_a = 32'h0000_2000; id_b = 32'h0000_00AA;
  endtask

  initial begin
    // 1. reset with random inputs
    rst_n = 1'b0;
    for (int i = 0; i < 2; i++) begin
      en = 1'($urandom); flush = 1'($urandom); id_valid = 1'($urandom);
      id_inst = $urandom; id_we_st = 1'($urandom); id_we_r = 1'($urandom);
      id_ma = 1'($urandom); id_dest = 5'($urandom); id_alu = 4'($urandom);
      id_imm = 16'($urandom); id_cin = 1'($urandom); id_a = $urandom; id_b = $urandom;
      tick();
    end
    chk("rst_valid", {31'd0, ex_valid}, 32'd0);
    chk("rst_we_r", {31'd0, ex_we_r}, 32'd0);
    chk("rst_ma", {31'd0, ex_ma}, 32'd0);
    chk("rst_dest", {27'd0, ex_dest}, 32'd0);
    chk("rst_a", ex_a, 32'd0);
    chk("rst_imm", {16'd0, ex_imm}, 32'd0);
    chk("rst_cnt", {28'd0, bubble_cnt}, 32'd0);
    chk("rst_stall", {31'd0, stall_id}, 32'd0);

    rst_n = 1'b1; en = 1'b1; flush = 1'b0;
    drive_add(5'd1, 5'd2, 5'd3, 32'h0000_0011, 32'h0000_0022);
    tick();
    chk("add_valid", {31'd0, ex_valid}, 32'd1);
    chk("add_dest", {27'd0, ex_dest}, 32'd3);
    chk("add_we_r", {31'd0, ex_we_r}, 32'd1);
    chk("add_rs", {27'd0, ex_rs}, 32'd1);
    chk("add_rt", {27'd0, ex_rt}, 32'd2);
    chk("add_a", ex_a, 32'h0000_0011);
    chk("add_b", ex_b, 32'h0000_0022);

    // 2. load-use: lw r5,0(r1); add r6,r5,r2
    drive_lw(5'd1, 5'd5, 5'd5, 16'd0);
    tick();
    drive_add(5'd5, 5'd2, 5'd6, 32'h0000_0055, 32'h0000_0002);
    #1;
    chk("lu_stall", {31'd0, stall_id}, 32'd1);
    tick();
    chk("lu_bub_valid", {31'd0, ex_valid}, 32'd0);
    chk("lu_bub_we_r", {31'd0, ex_we_r}, 32'd0);
    chk("lu_cnt", {28'd0, bubble_cnt}, 32'd1);
    chk("lu_stall_drop", {31'd0, stall_id}, 32'd0);
    tick();
    chk("lu_add_valid", {31'd0, ex_valid}, 32'd1);
    chk("lu_add_rs", {27'd0, ex_rs}, 32'd5);
    chk("lu_add_dest", {27'd0, ex_dest}, 32'd6);
    chk("lu_after_stall", {31'd0, stall_id}, 32'd0);

    // 3a. load to r0 never stalls
    drive_lw(5'd1, 5'd0, 5'd0, 16'd0);
    tick();
    drive_add(5'd0, 5'd0, 5'd7, 32'h0, 32'h0);
    #1;
    chk("r0_stall", {31'd0, stall_id}, 32'd0);
    tick();
    chk("r0_valid", {31'd0, ex_valid}, 32'd1);
    chk("r0_cnt", {28'd0, bubble_cnt}, 32'd1);

    // 3b. lw r5 then lw r7,0(r5): one stall
    drive_lw(5'd1, 5'd5, 5'd5, 16'd0);
    tick();
    drive_lw(5'd5, 5'd7, 5'd7, 16'd0);
    #1;
    chk("ll_stall", {31'd0, stall_id}, 32'd1);
    tick();
    chk("ll_cnt", {28'd0, bubble_cnt}, 32'd2);
    chk("ll_stall_drop", {31'd0, stall_id}, 32'd0);
    tick();
    chk("ll_dest", {27'd0, ex_dest}, 32'd7);
    chk("ll_ma", {31'd0, ex_ma}, 32'd1);

    // 3c. lw r5 then lw r7,0(r4) with rt field 5: lw ignores rt
    drive_lw(5'd1, 5'd5, 5'd5, 16'd0);
    #1;
    chk("lx_stall0", {31'd0, stall_id}, 32'd0);
    tick();
    drive_lw(5'd4, 5'd5, 5'd7, 16'd0);
    #1;
    chk("lx_stall", {31'd0, stall_id}, 32'd0);
    tick();
    chk("lx_valid", {31'd0, ex_valid}, 32'd1);
    chk("lx_cnt", {28'd0, bubble_cnt}, 32'd2);

    // 4. lw r8 then sw r8,4(r2): rt dependency
    drive_lw(5'd1, 5'd8, 5'd8, 16'd0);
    tick();
    drive_sw(5'd2, 5'd8, 16'd4);
    #1;
    chk("sw_stall", {31'd0, stall_id}, 32'd1);
    tick();
    chk("sw_cnt", {28'd0, bubble_cnt}, 32'd3);
    chk("sw_bub_we_st", {31'd0, ex_we_st}, 32'd0);
    tick();
    chk("sw_valid", {31'd0, ex_valid}, 32'd1);
    chk("sw_we_st", {31'd0, ex_we_st}, 32'd1);
    chk("sw_imm", {16'd0, ex_imm}, 32'd4);
    chk("sw_rt", {27'd0, ex_rt}, 32'd8);

    // 5. flush during hazard with en=0
    drive_lw(5'd1, 5'd9, 5'd9, 16'd0);
    tick();
    drive_add(5'd9, 5'd3, 5'd10, 32'h0000_0099, 32'h0000_0033);
    #1;
    chk("fl_hazard_pre", {31'd0, stall_id}, 32'd1);
    en = 1'b0; flush = 1'b1;
    #1;
    chk("fl_stall", {31'd0, stall_id}, 32'd0);
    tick();
    chk("fl_valid", {31'd0, ex_valid}, 32'd0);
    chk("fl_ma", {31'd0, ex_ma}, 32'd0);
    chk("fl_cnt", {28'd0, bubble_cnt}, 32'd3);
    flush = 1'b0; en = 1'b1;
    tick();
    chk("hold_load_dest", {27'd0, ex_dest}, 32'd10);
    en = 1'b0;
    drive_lw(5'd11, 5'd12, 5'd12, 16'h0010);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("hold_valid", {31'd0, ex_valid}, 32'd1);
      chk("hold_dest", {27'd0, ex_dest}, 32'd10);
      chk("hold_rs", {27'd0, ex_rs}, 32'd9);
      chk("hold_a", ex_a, 32'h0000_0099);
      chk("hold_ma", {31'd0, ex_ma}, 32'd0);
    end
    en = 1'b1;

    // 6. saturation over 20 load-use pairs
    for (int i = 0; i < 20; i++) begin
      drive_lw(5'd1, 5'd5, 5'd5, 16'd0);
      tick();
      drive_add(5'd5, 5'd2, 5'd6, 32'h1, 32'h2);
      tick();
      chk("sat_cnt", {28'd0, bubble_cnt}, (i + 4 > 15) ? 32'd15 : 32'(i + 4));
      tick();
    end
    chk("sat_final", {28'd0, bubble_cnt}, 32'd15);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmps, errs);
    $finish;
  end

endmodule
